// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data SRAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam int unsigned MEM_LATENCY_DEFAULT = 1;

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter; done_out flags the last cycle of the SRAM read latency.
module mem_lat_timer #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_in,
    input  logic [CW-1:0] load_val_in,
    output logic          done_out
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_in) begin
            count_d = load_val_in;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_out = (count_q == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port synchronous SRAM,
// one transaction at a time, alternating grants under contention.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr_in,
    input  logic              i_addr_valid_in,
    input  logic              i_flush_in,
    output logic              i_ready_out,
    output logic              i_valid_out,
    output logic [31:0]       i_rdata_out,
    input  logic              d_valid_in,
    input  logic              d_read_en_in,
    input  logic              d_write_en_in,
    input  logic [31:0]       d_addr_in,
    input  logic [31:0]       d_wdata_in,
    input  logic [3:0]        d_byte_en_in,
    output logic              d_ready_out,
    output logic              d_valid_out,
    output logic [31:0]       d_rdata_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [3:0]        mem_be_out,
    output logic [MEM_AW-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    input  logic [31:0]       mem_rdata_in
);

    localparam int unsigned TW = $clog2(MEM_LATENCY + 1);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    grant_t            last_q, last_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              we_q, we_d;
    logic              kill_q, kill_d;
    logic [31:0]       resp_q, resp_d;
    logic [31:0]       i_hold_q, i_hold_d;
    logic [31:0]       d_hold_q, d_hold_d;

    logic instr_req, data_req, pick_data, timer_load, timer_done, issue;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_in[31:MEM_AW+2], i_addr_in[1:0],
                                d_addr_in[31:MEM_AW+2], d_addr_in[1:0]};

    mem_lat_timer #(.CW(TW)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load_in     (timer_load),
        .load_val_in (TW'(MEM_LATENCY)),
        .done_out    (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        kill_d     = kill_q;
        resp_d     = resp_q;
        i_hold_d   = i_hold_q;
        d_hold_d   = d_hold_q;
        timer_load = 1'b0;

        instr_req = i_addr_valid_in && !i_flush_in;
        data_req  = d_valid_in && (d_read_en_in || d_write_en_in);
        pick_data = data_req && (!instr_req || last_q != GRANT_DATA);

        unique case (state_q)
            ARB_IDLE: begin
                kill_d = 1'b0;
                if (instr_req || data_req) begin
                    grant_d = pick_data ? GRANT_DATA : GRANT_INSTR;
                    last_d  = grant_d;
                    addr_d  = pick_data ? d_addr_in[MEM_AW+1:2] : i_addr_in[MEM_AW+1:2];
                    we_d    = pick_data && d_write_en_in;
                    be_d    = we_d ? d_byte_en_in : 4'hF;
                    wdata_d = pick_data ? d_wdata_in : '0;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                timer_load = 1'b1;
                state_d    = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (timer_done) begin
                    resp_d  = we_q ? '0 : mem_rdata_in;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        // A flush anywhere in an instr transaction kills its response, including in RESP itself.
        if (state_q != ARB_IDLE && grant_q == GRANT_INSTR && i_flush_in) begin
            kill_d = 1'b1;
        end

        issue       = (state_q == ARB_ISSUE);
        i_ready_out = issue && (grant_q == GRANT_INSTR);
        d_ready_out = issue && (grant_q == GRANT_DATA);
        i_valid_out = (state_q == ARB_RESP) && (grant_q == GRANT_INSTR) && !kill_q && !i_flush_in;
        d_valid_out = (state_q == ARB_RESP) && (grant_q == GRANT_DATA);

        if (i_valid_out) i_hold_d = resp_q;
        if (d_valid_out) d_hold_d = resp_q;
        i_rdata_out = i_valid_out ? resp_q : i_hold_q;
        d_rdata_out = d_valid_out ? resp_q : d_hold_q;

        mem_req_out   = issue;
        mem_we_out    = issue && we_q;
        mem_be_out    = issue ? be_q : '0;
        mem_addr_out  = issue ? addr_q : '0;
        mem_wdata_out = issue ? wdata_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= GRANT_INSTR;
            last_q   <= GRANT_INSTR;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            kill_q   <= 1'b0;
            resp_q   <= '0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            kill_q   <= kill_d;
            resp_q   <= resp_d;
            i_hold_q <= i_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at latency 1, one at latency 3.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_addr_valid, i_flush, d_valid, d_read_en, d_write_en;
    logic [3:0]  d_byte_en;

    logic        a_i_ready, a_i_valid, a_d_ready, a_d_valid, a_mem_req, a_mem_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_be;
    logic [9:0]  a_mem_addr;
    logic        z_i_ready, z_i_valid, z_d_ready, z_d_valid, z_mem_req, z_mem_we;
    logic [31:0] z_i_rdata, z_d_rdata, z_mem_wdata, z_mem_rdata;
    logic [3:0]  z_mem_be;
    logic [9:0]  z_mem_addr;

    mem_arbiter #(.MEM_AW(10), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst),
        .i_addr_in(i_addr), .i_addr_valid_in(i_addr_valid), .i_flush_in(i_flush),
        .i_ready_out(a_i_ready), .i_valid_out(a_i_valid), .i_rdata_out(a_i_rdata),
        .d_valid_in(d_valid), .d_read_en_in(d_read_en), .d_write_en_in(d_write_en),
        .d_addr_in(d_addr), .d_wdata_in(d_wdata), .d_byte_en_in(d_byte_en),
        .d_ready_out(a_d_ready), .d_valid_out(a_d_valid), .d_rdata_out(a_d_rdata),
        .mem_req_out(a_mem_req), .mem_we_out(a_mem_we), .mem_be_out(a_mem_be),
        .mem_addr_out(a_mem_addr), .mem_wdata_out(a_mem_wdata), .mem_rdata_in(a_mem_rdata)
    );

    mem_arbiter #(.MEM_AW(10), .MEM_LATENCY(3)) dut_z (
        .clk(clk), .rst(rst),
        .i_addr_in(i_addr), .i_addr_valid_in(i_addr_valid), .i_flush_in(i_flush),
        .i_ready_out(z_i_ready), .i_valid_out(z_i_valid), .i_rdata_out(z_i_rdata),
        .d_valid_in(d_valid), .d_read_en_in(d_read_en), .d_write_en_in(d_write_en),
        .d_addr_in(d_addr), .d_wdata_in(d_wdata), .d_byte_en_in(d_byte_en),
        .d_ready_out(z_d_ready), .d_valid_out(z_d_valid), .d_rdata_out(z_d_rdata),
        .mem_req_out(z_mem_req), .mem_we_out(z_mem_we), .mem_be_out(z_mem_be),
        .mem_addr_out(z_mem_addr), .mem_wdata_out(z_mem_wdata), .mem_rdata_in(z_mem_rdata)
    );

    // {i_ready, i_valid, d_ready, d_valid, mem_req, mem_we}
    logic [5:0] va, vz;
    assign va = {a_i_ready, a_i_valid, a_d_ready, a_d_valid, a_mem_req, a_mem_we};
    assign vz = {z_i_ready, z_i_valid, z_d_ready, z_d_valid, z_mem_req, z_mem_we};

    function automatic logic [31:0] preload(input int w);
        case (w)
            4:       return 32'h0050_0093;
            5:       return 32'hAABB_CCDD;
            6:       return 32'h1122_3344;
            9:       return 32'h1234_5678;
            default: return 32'h0;
        endcase
    endfunction

    // SRAM models: read data is valid for exactly one cycle, LATENCY cycles after the strobe.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_z [0:1023];
    logic [31:0] pipe_a;
    logic [31:0] pipe_z [0:2];
    assign a_mem_rdata = pipe_a;
    assign z_mem_rdata = pipe_z[2];

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 1024; w++) mem_a[w] <= preload(w);
            pipe_a <= '0;
        end else begin
            pipe_a <= 32'hBAD0_BAD0;
            if (a_mem_req && a_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (a_mem_be[b]) mem_a[a_mem_addr][8*b +: 8] <= a_mem_wdata[8*b +: 8];
            end else if (a_mem_req) begin
                pipe_a <= mem_a[a_mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 1024; w++) mem_z[w] <= preload(w);
            for (int s = 0; s < 3; s++) pipe_z[s] <= '0;
        end else begin
            pipe_z[0] <= 32'hBAD0_BAD0;
            pipe_z[1] <= pipe_z[0];
            pipe_z[2] <= pipe_z[1];
            if (z_mem_req && z_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (z_mem_be[b]) mem_z[z_mem_addr][8*b +: 8] <= z_mem_wdata[8*b +: 8];
            end else if (z_mem_req) begin
                pipe_z[0] <= mem_z[z_mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single fetch on the latency-1 instance, starting in an IDLE cycle.
    task automatic fetch_a(input string tag, input logic [31:0] addr, input logic [31:0] word);
        i_addr = addr;
        i_addr_valid = 1'b1;
        check({tag, "_t0"}, va, 6'b000000);
        tick();
        check({tag, "_t1"}, va, 6'b100010);
        check({tag, "_addr"}, a_mem_addr, addr[11:2]);
        check({tag, "_be"}, a_mem_be, 4'hF);
        i_addr_valid = 1'b0;
        tick();
        check({tag, "_t2"}, va, 6'b000000);
        tick();
        check({tag, "_t3"}, va, 6'b010000);
        check({tag, "_rdata"}, a_i_rdata, word);
        tick();
        check({tag, "_t4"}, va, 6'b000000);
        check({tag, "_hold"}, a_i_rdata, word);
    endtask

    logic [5:0] seq3 [0:11];

    initial begin
        seq3 = '{6'b000000, 6'b001010, 6'b000000, 6'b000100,
                 6'b000000, 6'b100010, 6'b000000, 6'b010000,
                 6'b000000, 6'b001010, 6'b000000, 6'b000100};
        i_addr = '0; i_addr_valid = 0; i_flush = 0;
        d_valid = 0; d_read_en = 0; d_write_en = 0;
        d_addr = '0; d_wdata = '0; d_byte_en = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_ctl_a", va, 6'b000000);
        check("reset_ctl_z", vz, 6'b000000);
        check("reset_irdata", a_i_rdata, 32'h0);
        check("reset_drdata", a_d_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // 1: instruction-only fetch
        fetch_a("t1", 32'h10, 32'h0050_0093);

        // 3: contention, both held for three transactions
        i_addr = 32'h10; i_addr_valid = 1'b1;
        d_addr = 32'h24; d_read_en = 1'b1; d_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("t3_c%0d", c), va, seq3[c]);
            if (c == 3 || c == 11) check($sformatf("t3_drdata_c%0d", c), a_d_rdata, 32'h1234_5678);
            if (c == 7) check("t3_irdata", a_i_rdata, 32'h0050_0093);
            if (c == 11) begin
                i_addr_valid = 1'b0;
                d_valid = 1'b0;
            end
            tick();
        end
        check("t3_idle", va, 6'b000000);

        // 2: partial store then load of the same word
        d_valid = 1'b1; d_write_en = 1'b1; d_read_en = 1'b0;
        d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_byte_en = 4'b0011;
        tick();
        check("t2_st_issue", va, 6'b001011);
        check("t2_st_be", a_mem_be, 4'b0011);
        check("t2_st_addr", a_mem_addr, 10'd8);
        check("t2_st_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        d_valid = 1'b0;
        tick();
        check("t2_st_wait", va, 6'b000000);
        tick();
        check("t2_st_resp", va, 6'b000100);
        check("t2_st_rdata", a_d_rdata, 32'h0);
        tick();
        check("t2_idle", va, 6'b000000);
        d_valid = 1'b1; d_write_en = 1'b0; d_read_en = 1'b1;
        tick();
        check("t2_ld_issue", va, 6'b001010);
        check("t2_ld_be", a_mem_be, 4'hF);
        d_valid = 1'b0;
        tick();
        tick();
        check("t2_ld_resp", va, 6'b000100);
        check("t2_ld_rdata", a_d_rdata, 32'h0000_BEEF);
        d_read_en = 1'b0;
        tick();

        // 4: flush during WAIT, then refetch at the new address
        i_addr = 32'h14; i_addr_valid = 1'b1;
        tick();
        check("t4_issue", va, 6'b100010);
        check("t4_addr", a_mem_addr, 10'd5);
        i_addr = 32'h18;
        tick();
        i_flush = 1'b1;
        check("t4_wait", va, 6'b000000);
        tick();
        i_flush = 1'b0;
        check("t4_killed", va, 6'b000000);
        check("t4_irdata_hold", a_i_rdata, 32'h0050_0093);
        tick();
        check("t4_idle", va, 6'b000000);
        tick();
        check("t4_reissue", va, 6'b100010);
        check("t4_readdr", a_mem_addr, 10'd6);
        i_addr_valid = 1'b0;
        tick();
        tick();
        check("t4_resp", va, 6'b010000);
        check("t4_rdata", a_i_rdata, 32'h1122_3344);
        tick();

        // Flush in IDLE masks the fetch for that cycle only
        i_addr = 32'h10; i_addr_valid = 1'b1; i_flush = 1'b1;
        tick();
        check("t4_masked", va, 6'b000000);
        i_flush = 1'b0;
        tick();
        check("t4_unmasked", va, 6'b100010);
        i_addr_valid = 1'b0;
        tick();
        tick();
        check("t4_unmasked_resp", va, 6'b010000);
        tick();

        // 5: asynchronous reset in the middle of WAIT
        i_addr = 32'h14; i_addr_valid = 1'b1;
        tick();
        i_addr_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("t5_async_ctl", va, 6'b000000);
        check("t5_async_irdata", a_i_rdata, 32'h0);
        check("t5_async_drdata", a_d_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        fetch_a("t5", 32'h10, 32'h0050_0093);

        // 6: latency-3 instance, load and a wrapping fetch
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        d_addr = 32'h24; d_read_en = 1'b1; d_valid = 1'b1;
        check("t6_ld_t0", vz, 6'b000000);
        tick();
        check("t6_ld_issue", vz, 6'b001010);
        check("t6_ld_addr", z_mem_addr, 10'd9);
        d_valid = 1'b0;
        for (int c = 2; c < 5; c++) begin
            tick();
            check($sformatf("t6_ld_t%0d", c), vz, 6'b000000);
        end
        tick();
        check("t6_ld_resp", vz, 6'b000100);
        check("t6_ld_rdata", z_d_rdata, 32'h1234_5678);
        d_read_en = 1'b0;
        tick();
        i_addr = 32'hFFFF_F010; i_addr_valid = 1'b1;
        tick();
        check("t6_if_issue", vz, 6'b100010);
        check("t6_if_wrap", z_mem_addr, 10'd4);
        i_addr_valid = 1'b0;
        repeat (3) tick();
        check("t6_if_early", vz, 6'b000000);
        tick();
        check("t6_if_resp", vz, 6'b010000);
        check("t6_if_rdata", z_i_rdata, 32'h0050_0093);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
